// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing unit for the bitty core.
// Fetches one word, then issues it to bitty, branches on d_out, or halts.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] START_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [15:0]       mem_rd_data,
  output logic [15:0]       d_instr,
  output logic              run,
  input  logic              done,
  input  logic [15:0]       d_out,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nx;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_target;
  logic [15:0]       ir;
  logic [1:0]        br_cond;
  logic              is_halt;
  logic              is_br;
  logic              is_norm;
  logic              taken;

  assign pc_inc    = pc_q + 1'b1;
  assign br_target = ir[ADDR_W+3:4];
  assign br_cond   = ir[3:2];

  // Halt word also has bits[1:0]=11, so it must mask the branch decode.
  assign is_halt = (ir == 16'hFFFF);
  assign is_br   = !is_halt && (ir[1:0] == 2'b11);
  assign is_norm = !is_halt && !is_br;

  always_comb begin
    taken = 1'b0;
    unique case (br_cond)
      2'b00: taken = (d_out == 16'd0);
      2'b01: taken = (d_out != 16'd0);
      2'b10: taken = d_out[15];
      2'b11: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: state_nx = S_LATCH;
      S_LATCH: state_nx = S_ISSUE;
      S_ISSUE: begin
        unique case (1'b1)
          is_halt: state_nx = S_HALT;
          is_br: begin
            state_nx = S_FETCH;
            pc_nx    = taken ? br_target : pc_inc;
          end
          is_norm: state_nx = S_EXEC;
          default: state_nx = S_IDLE;
        endcase
      end
      S_EXEC: begin
        if (done) begin
          state_nx = S_FETCH;
          pc_nx    = pc_inc;
        end
      end
      S_HALT: begin
        if (start) begin
          state_nx = S_FETCH;
          pc_nx    = START_PC;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      pc_q  <= START_PC;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir <= 16'd0;
    end else if (state == S_LATCH) begin
      ir <= mem_rd_data;
    end
  end

  // run is decoded from state so an async reset drops it at once.
  assign run       = (state == S_EXEC);
  assign mem_rd_en = (state == S_FETCH);
  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign d_instr   = ir;
  assign halted    = (state == S_HALT);
  assign busy      = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, instruction memory address width.
REQ-002 Parameter START_PC, default 0, PC value after reset and after restart from HALT.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin or resume fetching, level sampled in IDLE/HALT.
REQ-006 mem_addr  output  ADDR_W  instruction memory read address.
REQ-007 mem_rd_en  output  1  instruction memory read strobe.
REQ-008 mem_rd_data  input  16  instruction word, valid exactly 1 cycle after mem_rd_en.
REQ-009 d_instr  output  16  instruction presented to bitty.
REQ-010 run  output  1  bitty enable, held high until done.
REQ-011 done  input  1  bitty completion pulse.
REQ-012 d_out  input  16  bitty last ALU result, used for branch conditions.
REQ-013 pc  output  ADDR_W  current program counter.
REQ-014 busy  output  1  high in any state except IDLE and HALT.
REQ-015 halted  output  1  high in HALT state.

Function
REQ-016 The block SHALL implement the states IDLE, FETCH, LATCH, ISSUE, EXEC and HALT.
REQ-017 IDLE: start=1 -> FETCH; otherwise hold.
REQ-018 FETCH: mem_rd_en=1, mem_addr=pc, for exactly one cycle; next LATCH.
REQ-019 LATCH: capture mem_rd_data into the instruction register driving d_instr; next ISSUE.
REQ-020 ISSUE: decode the latched word in this priority: 16'hFFFF = halt -> HALT, pc unchanged; bits[1:0]=2'b11 = branch; else normal -> EXEC.
REQ-021 Branch: target = bits[ADDR_W+3:4], cond = bits[3:2]; 00 taken if d_out==0, 01 taken if d_out!=0, 10 taken if d_out[15]=1, 11 always taken.
REQ-022 Branch SHALL NOT assert run; taken -> pc=target, not taken -> pc=pc+1; next FETCH; d_out sampled in the ISSUE cycle.
REQ-023 EXEC: run=1 from the first EXEC cycle until the cycle done is sampled high; on that edge pc=pc+1, run drops, next FETCH.
REQ-024 done sampled outside EXEC SHALL be ignored.
REQ-025 d_instr SHALL remain stable from LATCH until the next LATCH.
REQ-026 pc increment SHALL wrap modulo 2^ADDR_W (255 -> 0 for ADDR_W=8).
REQ-027 HALT: start=1 -> pc=START_PC, next FETCH; otherwise hold.
REQ-028 start while busy SHALL have no effect.
REQ-029 Normal instruction latency: run rises 3 cycles after the FETCH cycle begins; next FETCH on the cycle after done.
REQ-030 mem_rd_en SHALL be 0 in all states except FETCH; mem_addr SHALL equal pc at all times.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, pc=START_PC, d_instr=0, run=0, mem_rd_en=0, busy=0, halted=0, independent of clk.
REQ-032 Reset asserted mid-EXEC SHALL drop run asynchronously; a later done SHALL be ignored.
REQ-033 After reset release, the block SHALL stay in IDLE until start=1 is sampled.

Verification
REQ-034 Reset, start=1, mem[0]=16'h1234, done pulsed 2 cycles after run rises -> mem_rd_en at cycle 0, run high at cycle 3, d_instr=16'h1234, pc=1, FETCH on next cycle.
REQ-035 mem[5]=branch cond 00 target 8'h20, d_out=0 -> no run pulse, pc=8'h20; repeat with d_out=16'h0001 -> pc=6.
REQ-036 mem[2]=16'hFFFF -> halted=1, busy=0, pc=2; start=1 -> pc=START_PC, FETCH resumes.
REQ-037 pc=8'hFF with a normal instruction completed -> pc wraps to 8'h00, next mem_addr=8'h00.
REQ-038 reset=0 asserted while run=1 and before done -> run=0 without a clock edge, pc=START_PC, later done pulse ignored, stays IDLE.
REQ-039 start held high during EXEC and done held low for 10 cycles -> run stays high, pc and d_instr unchanged throughout.
